// File: rtl/mem_access_unit_if.sv
// Word-wide data memory port: request/ready for commands, rvalid for read data.
// master = mem_access_unit, slave = memory.
interface mem_access_unit_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        ready;
    logic [31:0] rdata;
    logic        rvalid;

    modport master (output req, we, addr, wd, input ready, rdata, rvalid);
    modport slave  (input req, we, addr, wd, output ready, rdata, rvalid);
endinterface

// File: rtl/mem_access_unit.sv
// Memory-stage unit: one load/store/pass-through at a time, sub-word sign/zero
// handling on loads, read-modify-write for byte/half stores, registered outputs.
module mem_access_unit (
    input  logic                CLK,
    input  logic                RST,
    input  logic                valid_in,
    output logic                ready_out,
    input  logic                is_load,
    input  logic                is_store,
    input  logic [2:0]          funct3,
    input  logic [31:0]         addr,
    input  logic [31:0]         wd,
    input  logic                we_in,
    input  logic [4:0]          rd_in,
    mem_access_unit_if.master   mem,
    output logic                valid_out,
    output logic [31:0]         loaded,
    output logic                we_reg,
    output logic [4:0]          rd_out,
    output logic                misaligned
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_REQ  = 3'd1;
    localparam logic [2:0] RD_WAIT = 3'd2;
    localparam logic [2:0] WR_REQ  = 3'd3;
    localparam logic [2:0] DONE    = 3'd4;

    logic [2:0]  state_reg;
    logic [1:0]  addr_lo_reg;
    logic [15:0] wd_reg;
    logic [2:0]  f3_reg;
    logic [4:0]  rd_reg;
    logic        load_reg;
    logic        ready_reg;
    logic        req_reg;
    logic        mem_we_reg;
    logic [31:0] mem_addr_reg;
    logic [31:0] mem_wd_reg;
    logic        valid_reg;
    logic [31:0] loaded_reg;
    logic        wb_we_reg;
    logic [4:0]  rd_out_reg;
    logic        mis_reg;

    logic        accept;
    logic        is_mem;
    logic        f3_legal;
    logic        bad_align;
    logic        fault;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_val;
    logic [3:0]  lane_mask;
    logic [31:0] merged;

    assign accept    = valid_in && ready_reg;
    assign is_mem    = is_load || is_store;
    assign f3_legal  = is_load ? (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                               : (funct3 inside {3'b000, 3'b001, 3'b010});
    assign bad_align = ((funct3[1:0] == 2'b01) && addr[0]) ||
                       ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    assign fault     = is_mem && (!f3_legal || bad_align);

    assign byte_lane = mem.rdata[{addr_lo_reg, 3'b000} +: 8];
    assign half_lane = addr_lo_reg[1] ? mem.rdata[31:16] : mem.rdata[15:0];

    always_comb begin
        load_val = mem.rdata;
        case (f3_reg)
            3'b000:  load_val = {{24{byte_lane[7]}}, byte_lane};
            3'b100:  load_val = {24'h0, byte_lane};
            3'b001:  load_val = {{16{half_lane[15]}}, half_lane};
            3'b101:  load_val = {16'h0, half_lane};
            default: load_val = mem.rdata;
        endcase
    end

    // Lanes written by a sub-word store; halfword stores put wd[15:8] in the odd lane.
    assign lane_mask = f3_reg[0] ? (addr_lo_reg[1] ? 4'b1100 : 4'b0011)
                                 : (4'b0001 << addr_lo_reg);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_merge
            assign merged[gi*8 +: 8] = !lane_mask[gi] ? mem.rdata[gi*8 +: 8]
                                     : (f3_reg[0] ? wd_reg[(gi % 2)*8 +: 8] : wd_reg[7:0]);
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg    <= IDLE;
            addr_lo_reg  <= 2'b00;
            wd_reg       <= 16'h0;
            f3_reg       <= 3'b000;
            rd_reg       <= 5'd0;
            load_reg     <= 1'b0;
            ready_reg    <= 1'b1;
            req_reg      <= 1'b0;
            mem_we_reg   <= 1'b0;
            mem_addr_reg <= 32'h0;
            mem_wd_reg   <= 32'h0;
            valid_reg    <= 1'b0;
            loaded_reg   <= 32'h0;
            wb_we_reg    <= 1'b0;
            rd_out_reg   <= 5'd0;
            mis_reg      <= 1'b0;
        end else begin
            valid_reg <= 1'b0;
            wb_we_reg <= 1'b0;
            mis_reg   <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        ready_reg    <= 1'b0;
                        addr_lo_reg  <= addr[1:0];
                        wd_reg       <= wd[15:0];
                        f3_reg       <= funct3;
                        rd_reg       <= rd_in;
                        load_reg     <= is_load;
                        mem_addr_reg <= {addr[31:2], 2'b00};
                        if (!is_mem || fault) begin
                            state_reg  <= DONE;
                            valid_reg  <= 1'b1;
                            mis_reg    <= fault;
                            loaded_reg <= fault ? 32'h0 : addr;
                            wb_we_reg  <= !is_mem && we_in && (rd_in != 5'd0);
                            rd_out_reg <= rd_in;
                        end else if (!is_load && funct3 == 3'b010) begin
                            state_reg  <= WR_REQ;
                            req_reg    <= 1'b1;
                            mem_we_reg <= 1'b1;
                            mem_wd_reg <= wd;
                        end else begin
                            state_reg  <= RD_REQ;
                            req_reg    <= 1'b1;
                            mem_we_reg <= 1'b0;
                        end
                    end
                end
                RD_REQ: begin
                    if (mem.ready) begin
                        req_reg   <= 1'b0;
                        state_reg <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (mem.rvalid) begin
                        if (load_reg) begin
                            state_reg  <= DONE;
                            valid_reg  <= 1'b1;
                            loaded_reg <= load_val;
                            wb_we_reg  <= (rd_reg != 5'd0);
                            rd_out_reg <= rd_reg;
                        end else begin
                            state_reg  <= WR_REQ;
                            req_reg    <= 1'b1;
                            mem_we_reg <= 1'b1;
                            mem_wd_reg <= merged;
                        end
                    end
                end
                WR_REQ: begin
                    if (mem.ready) begin
                        req_reg    <= 1'b0;
                        mem_we_reg <= 1'b0;
                        state_reg  <= DONE;
                        valid_reg  <= 1'b1;
                        loaded_reg <= 32'h0;
                        rd_out_reg <= rd_reg;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    ready_reg <= 1'b1;
                end
                default: begin
                    state_reg <= IDLE;
                    ready_reg <= 1'b1;
                    req_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign ready_out  = ready_reg;
    assign mem.req    = req_reg;
    assign mem.we     = mem_we_reg;
    assign mem.addr   = mem_addr_reg;
    assign mem.wd     = mem_wd_reg;
    assign valid_out  = valid_reg;
    assign loaded     = loaded_reg;
    assign we_reg     = wb_we_reg;
    assign rd_out     = rd_out_reg;
    assign misaligned = mis_reg;
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios plus random operations against a
// word-array memory model and arithmetic expectations for latency and results.
module tb_mem_access_unit;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        valid_in = 1'b0;
    logic        ready_out;
    logic        is_load = 1'b0;
    logic        is_store = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] wd = 32'h0;
    logic        we_in = 1'b0;
    logic [4:0]  rd_in = 5'd0;
    logic        valid_out;
    logic [31:0] loaded;
    logic        we_reg;
    logic [4:0]  rd_out;
    logic        misaligned;

    mem_access_unit_if mif ();

    mem_access_unit dut (
        .CLK        (CLK),
        .RST        (RST),
        .valid_in   (valid_in),
        .ready_out  (ready_out),
        .is_load    (is_load),
        .is_store   (is_store),
        .funct3     (funct3),
        .addr       (addr),
        .wd         (wd),
        .we_in      (we_in),
        .rd_in      (rd_in),
        .mem        (mif),
        .valid_out  (valid_out),
        .loaded     (loaded),
        .we_reg     (we_reg),
        .rd_out     (rd_out),
        .misaligned (misaligned)
    );

    always #5 CLK = ~CLK;

    int          tests_run = 0;
    int          tests_failed = 0;
    logic [31:0] mem_model [0:63];
    logic [31:0] last_loaded;
    logic [31:0] last_wr_data;
    int          last_cycles;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_ready"},    ready_out,  1);
        check_eq({tag, "_req"},      mif.req,    0);
        check_eq({tag, "_mem_we"},   mif.we,     0);
        check_eq({tag, "_mem_addr"}, mif.addr,   0);
        check_eq({tag, "_mem_wd"},   mif.wd,     0);
        check_eq({tag, "_valid"},    valid_out,  0);
        check_eq({tag, "_loaded"},   loaded,     0);
        check_eq({tag, "_we_reg"},   we_reg,     0);
        check_eq({tag, "_rd_out"},   rd_out,     0);
        check_eq({tag, "_mis"},      misaligned, 0);
    endtask

    // Issues one instruction, acts as the memory, and checks the completion
    // against expectations derived from the operation's semantics.
    task automatic run_op(input bit ld, input bit st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d, input bit wen,
                          input logic [4:0] rd, input int stall, input int rdly);
        int          idx = int'(a[7:2]);
        logic [31:0] word = mem_model[idx];
        int          shamt = 8 * int'(a % 4);
        logic [31:0] sh = word >> shamt;
        logic [31:0] mask;
        bit          legal, fault;
        int          size;
        int          exp_cyc, exp_rd_n, exp_wr_n;
        logic [31:0] exp_loaded = 32'h0;
        logic [31:0] exp_wword = 32'h0;
        bit          exp_we = 1'b0;
        int          cyc, n_rd = 0, n_wr = 0, stall_left = stall, rd_cnt = 0;
        bit          rd_pending = 1'b0, done = 1'b0;
        logic [31:0] got_loaded = 32'h0;
        logic        got_we = 1'b0, got_mis = 1'b0;
        logic [4:0]  got_rd = 5'd0;

        legal = ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
        size  = 1 << f3[1:0];
        fault = (ld || st) && (!legal || ((a % size) != 0));
        exp_rd_n = 0;
        exp_wr_n = 0;
        if (fault) begin
            exp_cyc = 1;
        end else if (!ld && !st) begin
            exp_cyc = 1;
            exp_loaded = a;
            exp_we = wen && (rd != 0);
        end else if (ld) begin
            exp_cyc = 3 + stall + rdly;
            exp_rd_n = 1;
            exp_we = (rd != 0);
            case (f3)
                3'd0:    exp_loaded = {{24{sh[7]}}, sh[7:0]};
                3'd4:    exp_loaded = {24'h0, sh[7:0]};
                3'd1:    exp_loaded = {{16{sh[15]}}, sh[15:0]};
                3'd5:    exp_loaded = {16'h0, sh[15:0]};
                default: exp_loaded = word;
            endcase
        end else begin
            exp_wr_n = 1;
            mask = (f3 == 3'd0) ? 32'hFF : (f3 == 3'd1) ? 32'hFFFF : 32'hFFFFFFFF;
            mask = mask << shamt;
            exp_wword = (word & ~mask) | ((d << shamt) & mask);
            if (f3 == 3'd2) begin
                exp_cyc = 2 + stall;
            end else begin
                exp_cyc = 4 + stall + rdly;
                exp_rd_n = 1;
            end
        end

        @(negedge CLK);
        check_eq("ready_idle", ready_out, 1);
        is_load = ld; is_store = st; funct3 = f3; addr = a; wd = d; we_in = wen; rd_in = rd;
        valid_in = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        valid_in = 1'b0;
        cyc = 1;
        while (!done && cyc <= 40) begin
            if (valid_out) begin
                done = 1'b1;
                got_loaded = loaded; got_we = we_reg; got_mis = misaligned; got_rd = rd_out;
            end else begin
                check_eq("busy_ready", ready_out, 0);
                mif.rvalid = 1'b0;
                mif.rdata = $urandom;
                if (rd_pending) begin
                    if (rd_cnt == 0) begin
                        mif.rvalid = 1'b1;
                        mif.rdata = mem_model[idx];
                        rd_pending = 1'b0;
                    end else begin
                        rd_cnt--;
                    end
                end else if ($urandom_range(0, 3) == 0) begin
                    mif.rvalid = 1'b1;
                end
                if (mif.req) begin
                    check_eq("req_addr", mif.addr, {a[31:2], 2'b00});
                    if (stall_left > 0) begin
                        mif.ready = 1'b0;
                        stall_left--;
                    end else begin
                        mif.ready = 1'b1;
                        if (mif.we) begin
                            n_wr++;
                            last_wr_data = mif.wd;
                            check_eq("wr_data", mif.wd, exp_wword);
                            mem_model[idx] = exp_wword;
                        end else begin
                            n_rd++;
                            rd_pending = 1'b1;
                            rd_cnt = rdly;
                        end
                    end
                end else begin
                    mif.ready = 1'($urandom_range(0, 1));
                end
                @(posedge CLK);
                @(negedge CLK);
                cyc++;
            end
        end
        mif.ready = 1'b0;
        mif.rvalid = 1'b0;
        check_eq("completed", done, 1);
        last_loaded = got_loaded;
        last_cycles = cyc;
        if (done) begin
            check_eq("latency", cyc, exp_cyc);
            check_eq("loaded", got_loaded, exp_loaded);
            check_eq("we_reg", got_we, exp_we);
            check_eq("rd_out", got_rd, rd);
            check_eq("misaligned", got_mis, fault);
            check_eq("n_reads", n_rd, exp_rd_n);
            check_eq("n_writes", n_wr, exp_wr_n);
            @(posedge CLK);
            @(negedge CLK);
            check_eq("valid_pulse", valid_out, 0);
            check_eq("ready_after", ready_out, 1);
        end
        $display("[TB] op ld=%0d st=%0d f3=%0d addr=%h wd=%h rd=%0d stall=%0d rdly=%0d -> loaded=%h we=%0d mis=%0d cyc=%0d",
                 ld, st, f3, a, d, rd, stall, rdly, got_loaded, got_we, got_mis, cyc);
    endtask

    initial begin
        logic [31:0] ra;
        logic [2:0]  rf;
        int          kind;
        bit          rl, rs;

        for (int i = 0; i < 64; i++) mem_model[i] = $urandom;
        mif.ready = 1'b0;
        mif.rvalid = 1'b0;
        mif.rdata = 32'h0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        check_reset_vals("reset");

        // Word store then word load
        run_op(0, 1, 3'd2, 32'h10, 32'hDEADBEEF, 0, 5'd3, 0, 0);
        check_eq("sw_data", last_wr_data, 32'hDEADBEEF);
        run_op(1, 0, 3'd2, 32'h10, 32'h0, 0, 5'd5, 0, 0);
        check_eq("lw_const", last_loaded, 32'hDEADBEEF);

        // Byte/half sign and zero extension
        mem_model[8] = 32'h80FF7F01;
        run_op(1, 0, 3'd0, 32'h23, 32'h0, 0, 5'd1, 0, 0);
        check_eq("lb_23", last_loaded, 32'hFFFFFF80);
        run_op(1, 0, 3'd4, 32'h23, 32'h0, 0, 5'd1, 0, 0);
        check_eq("lbu_23", last_loaded, 32'h00000080);
        run_op(1, 0, 3'd0, 32'h21, 32'h0, 0, 5'd1, 0, 0);
        check_eq("lb_21", last_loaded, 32'h0000007F);
        run_op(1, 0, 3'd1, 32'h22, 32'h0, 0, 5'd1, 0, 0);
        check_eq("lh_22", last_loaded, 32'hFFFF80FF);
        run_op(1, 0, 3'd5, 32'h22, 32'h0, 0, 5'd1, 0, 0);
        check_eq("lhu_22", last_loaded, 32'h000080FF);

        // Sub-word read-modify-write
        mem_model[12] = 32'h11223344;
        run_op(0, 1, 3'd0, 32'h31, 32'h000000AA, 0, 5'd0, 0, 0);
        check_eq("sb_merge", last_wr_data, 32'h1122AA44);
        run_op(0, 1, 3'd1, 32'h32, 32'h0000BEEF, 0, 5'd0, 0, 0);
        check_eq("sh_merge", last_wr_data, 32'hBEEFAA44);

        // Faults and pass-through
        run_op(1, 0, 3'd2, 32'h06, 32'h0, 0, 5'd4, 0, 0);
        run_op(1, 0, 3'd1, 32'h05, 32'h0, 0, 5'd4, 0, 0);
        run_op(1, 0, 3'd3, 32'h08, 32'h0, 0, 5'd4, 0, 0);
        run_op(0, 1, 3'd4, 32'h08, 32'h0, 0, 5'd4, 0, 0);
        run_op(0, 0, 3'd0, 32'hCAFEF00D, 32'h0, 1, 5'd9, 0, 0);

        // Memory stall: 3 cycles not ready, rvalid 2 cycles late
        run_op(1, 0, 3'd2, 32'h10, 32'h0, 0, 5'd6, 3, 2);
        check_eq("stall_latency", last_cycles, 8);

        // Reset while waiting for read data; late rvalid must be discarded
        @(negedge CLK);
        is_load = 1'b1; is_store = 1'b0; funct3 = 3'd2; addr = 32'h40; rd_in = 5'd7;
        valid_in = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        valid_in = 1'b0;
        mif.ready = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        mif.ready = 1'b0;
        RST = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        mif.rvalid = 1'b1;
        mif.rdata = 32'h12345678;
        check_reset_vals("rst_mid");
        for (int i = 0; i < 4; i++) begin
            @(posedge CLK);
            @(negedge CLK);
            mif.rvalid = 1'b0;
            check_eq("rst_no_valid", valid_out, 0);
            check_eq("rst_no_req", mif.req, 0);
        end
        $display("[TB] reset mid-load done");
        run_op(1, 0, 3'd2, 32'h40, 32'h0, 0, 5'd7, 0, 0);
        run_op(1, 0, 3'd2, 32'h44, 32'h0, 0, 5'd0, 0, 0);

        // Reset coincident with valid_in: nothing accepted
        @(negedge CLK);
        is_load = 1'b1; funct3 = 3'd2; addr = 32'h48; rd_in = 5'd2;
        valid_in = 1'b1;
        RST = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        valid_in = 1'b0;
        check_eq("rst_vin_ready", ready_out, 1);
        check_eq("rst_vin_req", mif.req, 0);
        @(posedge CLK);
        @(negedge CLK);
        check_eq("rst_vin_valid", valid_out, 0);
        check_eq("rst_vin_req2", mif.req, 0);
        $display("[TB] reset with valid_in done");

        // Random operations
        for (int n = 0; n < 200; n++) begin
            kind = $urandom_range(0, 3);
            rl = (kind == 1) || (kind == 3);
            rs = (kind == 2);
            rf = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) begin
                rf = rs ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5));
                if (rf == 3'd3) rf = 3'd4;
            end
            ra = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (rf[1:0] == 2'b10) ra[1:0] = 2'b00;
                if (rf[1:0] == 2'b01) ra[0] = 1'b0;
            end
            run_op(rl, rs, rf, ra, $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                   $urandom_range(0, 2), $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

- **Role:** pipeline memory-stage initiator that drives the word-wide data memory.
- **Function:** accepts one load/store/pass-through instruction at a time, performs size and sign handling for byte, halfword and word accesses, and returns a writeback record.
- **Memory port:** word-only, with request/ready and response-valid handshakes.
- **Sub-word stores:** performed as read-modify-write.
- **Placement:** sits between execute and writeback.

## Interface
Parameters:
- none (32-bit datapath, word-addressed memory fixed)

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  synchronous reset, active-high
- valid_in  in  1  instruction present
- ready_out  out  1  unit can accept; equals (state==IDLE)
- is_load / is_store  in  1 / 1  access type; both 0 = pass-through
- funct3  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr  in  32  byte address (pass-through: ALU result)
- wd  in  32  store data, low-aligned
- we_in  in  1  register-write request for pass-through
- rd_in  in  5  destination register
- mem_req  out  1  memory request valid
- mem_we  out  1  request is a write
- mem_addr  out  32  word address, bits [1:0] always 0
- mem_wd  out  32  full-word write data
- mem_ready  in  1  memory accepts request this cycle
- mem_rdata  in  32  read data
- mem_rvalid  in  1  read data valid
- valid_out  out  1  one-cycle completion pulse
- loaded  out  32  load result / pass-through value
- we_reg  out  1  writeback enable
- rd_out  out  5  destination register
- misaligned  out  1  one-cycle pulse with valid_out on a faulting access

## Operation
- **Accept:** valid_in & ready_out. Latch addr, wd, funct3, rd_in, we_in, type.
- **States:** IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE.
- **Transitions out of IDLE on accept:**
  - pass-through → DONE
  - fault → DONE
  - load → RD_REQ
  - word store → WR_REQ
  - byte/half store → RD_REQ (RMW)
- **Fault:** halfword with addr[0]=1, word with addr[1:0]≠0, or funct3 not valid for the type.
  - No memory request is issued.
  - Completion carries misaligned=1, we_reg=0, loaded=0.
- **RD_REQ:** mem_req=1, mem_we=0, mem_addr={addr[31:2],2'b00}. Leave on mem_ready → RD_WAIT.
- **RD_WAIT:** wait for mem_rvalid.
  - Load: extract the lane selected by addr[1:0] (byte) or addr[1] (half), then sign- or zero-extend per funct3 → DONE.
  - RMW: replace the target byte/half lane of mem_rdata with wd[7:0]/wd[15:0] → WR_REQ.
- **WR_REQ:** mem_req=1, mem_we=1, mem_wd = wd (word) or the merged word. Leave on mem_ready → DONE.
- **DONE:** valid_out=1 for one cycle → IDLE.
  - we_reg = (load & rd≠0 & no fault), or (pass-through & we_in & rd≠0).
  - Stores: we_reg=0, loaded=0.
  - Pass-through: loaded = addr.
- **mem_rvalid outside RD_WAIT:** ignored.
- **mem_req:** never asserted outside RD_REQ/WR_REQ.
- **Requests:** mem_addr, mem_we and mem_wd stay stable while mem_req=1 and mem_ready=0.

## Timing
- **Outputs:** all registered.
- **Reset values:** ready_out=1, mem_req=0, mem_we=0, mem_addr=0, mem_wd=0, valid_out=0, loaded=0, we_reg=0, rd_out=0, misaligned=0, state=IDLE.
- **Latency**, with mem_ready=1 and rvalid one cycle after the handshake (accept at cycle 0):

  | Access | valid_out cycle |
  |---|---|
  | pass-through / fault | 1 |
  | word store | 2 |
  | load | 3 |
  | sub-word store | 4 |

- **Memory stalls:** each cycle of mem_ready=0 or delayed rvalid adds one cycle.
- **Throughput:** ready_out=0 from the cycle after accept until DONE completes, so the next accept is possible the cycle after the valid_out pulse.
- **Reset mid-operation:** RST high during any state → IDLE on that edge.
  - mem_req low the following cycle.
  - No valid_out is produced.
  - Late mem_rvalid is discarded.
- **Simultaneous RST and valid_in:** reset wins; nothing accepted.

## Test plan
- **Word store then word load:** SW addr=0x10 wd=0xDEADBEEF → mem_we write of 0xDEADBEEF to 0x10, valid_out at cycle 2, we_reg=0. Then LW addr=0x10 rd=5 → loaded=0xDEADBEEF, we_reg=1, rd_out=5, valid_out at cycle 3.
- **Byte load sign/zero extension:** memory word 0x80FF7F01 at 0x20. LB 0x23 → 0xFFFFFF80; LBU 0x23 → 0x00000080; LB 0x21 → 0x0000007F; LH 0x22 → 0xFFFF80FF; LHU 0x22 → 0x000080FF.
- **Sub-word RMW:** word 0x11223344 at 0x30. SB 0x31 wd=0xAA → read, then write 0x1122AA44. SH 0x32 wd=0xBEEF → write 0xBEEFAA44. valid_out at cycle 4.
- **Misaligned/illegal:** LW 0x06, LH 0x05, load funct3=011 → no mem_req, valid_out at cycle 1, misaligned=1, we_reg=0.
- **Memory stall:** mem_ready held 0 for 3 cycles, rvalid 2 cycles late → mem_addr stable throughout, load completes 5 cycles later than nominal, ready_out=0 throughout.
- **Reset mid-load:** RST for one cycle while in RD_WAIT, rvalid arriving afterward → no valid_out, all outputs at reset values, next LW completes normally. Also: LW with rd=0 → valid_out=1, we_reg=0.
